// File: rtl/i2c_target_regs.sv
// I2C target responder: filtered START/STOP/bit decode, 7-bit address match, byte register port.
// Build option: define I2C_TARGET_CLK_STRETCH_EN to hold SCL low 16 clks before read loads and after writes.
module i2c_target_regs #(
  parameter logic [6:0]  DEV_ADDR       = 7'h42,
  parameter int unsigned REG_ADDR_WIDTH = 8,
  parameter int unsigned FILTER_LEN     = 3,
  parameter int unsigned SDA_HOLD       = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_scl_in,
  output logic                      o_scl_out,
  output logic                      o_scl_tri,
  input  logic                      i_sda_in,
  output logic                      o_sda_out,
  output logic                      o_sda_tri,
  output logic                      o_wr_stb,
  output logic [REG_ADDR_WIDTH-1:0] o_wr_addr,
  output logic [7:0]                o_wr_data,
  output logic [REG_ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [7:0]                i_rd_data,
  output logic                      o_busy
);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
    StWdata, StWdataAck, StRdata, StRdataAck, StWaitStop
  } state_e;

  localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
  localparam int unsigned HoldW = $clog2(SDA_HOLD + 1);

  logic [1:0]       scl_sync_q, sda_sync_q;
  logic             scl_filt_q, sda_filt_q, scl_prev_q, sda_prev_q;
  logic [FiltW-1:0] scl_cnt_q, sda_cnt_q;

  // Filtered lines only move after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      scl_cnt_q  <= '0;
      sda_cnt_q  <= '0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], i_scl_in};
      sda_sync_q <= {sda_sync_q[0], i_sda_in};
      scl_prev_q <= scl_filt_q;
      sda_prev_q <= sda_filt_q;
      if (scl_sync_q[1] == scl_filt_q) begin
        scl_cnt_q <= '0;
      end else if (scl_cnt_q == FiltW'(FILTER_LEN - 1)) begin
        scl_filt_q <= scl_sync_q[1];
        scl_cnt_q  <= '0;
      end else begin
        scl_cnt_q <= scl_cnt_q + FiltW'(1);
      end
      if (sda_sync_q[1] == sda_filt_q) begin
        sda_cnt_q <= '0;
      end else if (sda_cnt_q == FiltW'(FILTER_LEN - 1)) begin
        sda_filt_q <= sda_sync_q[1];
        sda_cnt_q  <= '0;
      end else begin
        sda_cnt_q <= sda_cnt_q + FiltW'(1);
      end
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_filt_q & ~scl_prev_q;
  assign scl_fall  = ~scl_filt_q & scl_prev_q;
  assign start_det = scl_filt_q & scl_prev_q & sda_prev_q & ~sda_filt_q;
  assign stop_det  = scl_filt_q & scl_prev_q & ~sda_prev_q & sda_filt_q;

  state_e                    state_q, state_d;
  logic [3:0]                bit_cnt_q, bit_cnt_d;
  logic [7:0]                shift_q, shift_d;
  logic                      rw_q, rw_d;
  logic [REG_ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                      wr_stb_q, wr_stb_d;
  logic [REG_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]                wr_data_q, wr_data_d;
  logic                      busy_q;
  logic                      load_req;
  logic                      str_load;
  logic                      load_pend;
  logic [7:0]                byte_in;
  logic                      byte_end;

  assign byte_in  = {shift_q[6:0], sda_filt_q};
  assign byte_end = scl_rise && (bit_cnt_q == 4'd7);

`ifdef I2C_TARGET_CLK_STRETCH_EN
  localparam bit StretchEn = 1'b1;
`else
  localparam bit StretchEn = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rw_d      = rw_q;
    ptr_d     = ptr_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    load_req  = 1'b0;
    if (start_det) begin
      state_d   = StAddr;
      bit_cnt_d = '0;
    end else if (stop_det) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
    end else begin
      unique case (state_q)
        StAddr, StPtr, StWdata: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
          if (byte_end) begin
            if (state_q == StAddr) begin
              rw_d    = sda_filt_q;
              state_d = (byte_in[7:1] == DEV_ADDR) ? StAddrAck : StWaitStop;
            end else if (state_q == StPtr) begin
              ptr_d   = REG_ADDR_WIDTH'(byte_in);
              state_d = StPtrAck;
            end else begin
              wr_stb_d  = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = byte_in;
              ptr_d     = ptr_q + REG_ADDR_WIDTH'(1);
              state_d   = StWdataAck;
            end
          end
        end
        StRdata: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (byte_end) state_d = StRdataAck;
          end else if (scl_fall && bit_cnt_q != 4'd0) begin
            shift_d = {shift_q[6:0], 1'b0};
          end
        end
        StAddrAck, StPtrAck, StWdataAck, StRdataAck: begin
          // bit_cnt 9 marks that the ACK clock has risen, so its fall ends the byte
          if (scl_rise) begin
            bit_cnt_d = 4'd9;
            if (state_q == StRdataAck) begin
              if (sda_filt_q) state_d = StWaitStop;
              else ptr_d = ptr_q + REG_ADDR_WIDTH'(1);
            end
          end else if (scl_fall && bit_cnt_q == 4'd9) begin
            bit_cnt_d = '0;
            if (state_q == StRdataAck || (state_q == StAddrAck && rw_q)) begin
              state_d  = StRdata;
              load_req = 1'b1;
            end else if (state_q == StAddrAck) begin
              state_d = StPtr;
            end else begin
              state_d = StWdata;
            end
          end
        end
        StIdle, StWaitStop: ;
        default: state_d = StIdle;
      endcase
      if (StretchEn ? str_load : load_req) shift_d = i_rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rw_q      <= 1'b0;
      ptr_q     <= '0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rw_q      <= rw_d;
      ptr_q     <= ptr_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= (state_d != StIdle);
    end
  end

  logic             sda_want;
  logic             sda_tri_q;
  logic [HoldW-1:0] hold_cnt_q;

  always_comb begin
    sda_want = 1'b1;
    unique case (state_q)
      StAddrAck, StPtrAck, StWdataAck: sda_want = 1'b0;
      StRdata:                         sda_want = shift_q[7] | load_pend;
      default:                         sda_want = 1'b1;
    endcase
  end

  // SDA only changes SDA_HOLD clks after SCL fall (or after a stretched read load).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_tri_q  <= 1'b1;
      hold_cnt_q <= '0;
    end else if (start_det || stop_det) begin
      sda_tri_q  <= 1'b1;
      hold_cnt_q <= '0;
    end else if (scl_fall || str_load) begin
      hold_cnt_q <= HoldW'(SDA_HOLD);
    end else if (hold_cnt_q != '0) begin
      hold_cnt_q <= hold_cnt_q - HoldW'(1);
      if (hold_cnt_q == HoldW'(1)) sda_tri_q <= sda_want;
    end
  end

`ifdef I2C_TARGET_CLK_STRETCH_EN
  logic [4:0] str_cnt_q;
  logic       scl_tri_q, load_pend_q, wr_arm_q;

  assign str_load  = load_pend_q && (str_cnt_q == 5'd1);
  assign load_pend = load_pend_q;
  assign o_scl_tri = scl_tri_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      str_cnt_q   <= '0;
      scl_tri_q   <= 1'b1;
      load_pend_q <= 1'b0;
      wr_arm_q    <= 1'b0;
    end else if (start_det || stop_det) begin
      str_cnt_q   <= '0;
      scl_tri_q   <= 1'b1;
      load_pend_q <= 1'b0;
      wr_arm_q    <= 1'b0;
    end else begin
      if (wr_stb_q) wr_arm_q <= 1'b1;
      if (load_req) begin
        str_cnt_q   <= 5'd16;
        scl_tri_q   <= 1'b0;
        load_pend_q <= 1'b1;
      end else if (scl_fall && wr_arm_q) begin
        str_cnt_q <= 5'd16;
        scl_tri_q <= 1'b0;
        wr_arm_q  <= 1'b0;
      end else if (str_cnt_q != 5'd0) begin
        str_cnt_q <= str_cnt_q - 5'd1;
        if (str_cnt_q == 5'd1) begin
          scl_tri_q   <= 1'b1;
          load_pend_q <= 1'b0;
        end
      end
    end
  end
`else
  assign str_load  = 1'b0;
  assign load_pend = 1'b0;
  assign o_scl_tri = 1'b1;
`endif

  assign o_scl_out = 1'b0;
  assign o_sda_out = 1'b0;
  assign o_sda_tri = sda_tri_q;
  assign o_wr_stb  = wr_stb_q;
  assign o_wr_addr = wr_addr_q;
  assign o_wr_data = wr_data_q;
  assign o_rd_addr = ptr_q;
  assign o_busy    = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: bit-banged I2C master on a wired-AND bus model.
module tb_i2c_target_regs;
  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m_scl, m_sda, glitch;
  logic       scl_line, sda_line;
  logic       o_scl_out, o_scl_tri, o_sda_out, o_sda_tri, o_wr_stb, o_busy;
  logic [7:0] o_wr_addr, o_wr_data, o_rd_addr, i_rd_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign scl_line  = m_scl & (o_scl_tri | o_scl_out);
  assign sda_line  = (m_sda ^ glitch) & (o_sda_tri | o_sda_out);
  // Register file contents seen by reads
  assign i_rd_data = (o_rd_addr == 8'h20) ? 8'h3C : (o_rd_addr == 8'h21) ? 8'hC3 : 8'h00;

  i2c_target_regs dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_scl_in  (scl_line),
    .o_scl_out (o_scl_out),
    .o_scl_tri (o_scl_tri),
    .i_sda_in  (sda_line),
    .o_sda_out (o_sda_out),
    .o_sda_tri (o_sda_tri),
    .o_wr_stb  (o_wr_stb),
    .o_wr_addr (o_wr_addr),
    .o_wr_data (o_wr_data),
    .o_rd_addr (o_rd_addr),
    .i_rd_data (i_rd_data),
    .o_busy    (o_busy)
  );

  int         stb_n     = 0;
  int         drove_cnt = 0;
  logic [7:0] stb_a [32];
  logic [7:0] stb_d [32];

  always @(negedge clk) begin
    if (o_wr_stb && stb_n < 32) begin
      stb_a[stb_n] <= o_wr_addr;
      stb_d[stb_n] <= o_wr_data;
      stb_n        <= stb_n + 1;
    end
    if (!o_sda_tri) drove_cnt <= drove_cnt + 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic g, output logic s);
    int n;
    wclk(Q);
    m_sda = b;
    wclk(Q);
    m_scl = 1'b1;
    n = 0;
    while (!scl_line && n < 200) begin
      wclk(1);
      n++;
    end
    if (!scl_line) check("scl_release", 32'(scl_line), 32'd1);
    wclk(Q / 2);
    if (g) begin
      glitch = 1'b1;
      wclk(1);
      glitch = 1'b0;
    end
    wclk(Q / 2);
    s = sda_line;
    wclk(Q);
    m_scl = 1'b0;
  endtask

  task automatic i2c_start();
    wclk(Q);
    m_sda = 1'b1;
    wclk(Q);
    m_scl = 1'b1;
    wclk(2 * Q);
    m_sda = 1'b0;
    wclk(2 * Q);
    m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wclk(Q);
    m_sda = 1'b0;
    wclk(Q);
    m_scl = 1'b1;
    wclk(2 * Q);
    m_sda = 1'b1;
    wclk(2 * Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input logic [7:0] gmask, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(d[i], gmask[i], s);
    send_bit(1'b1, 1'b0, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, 1'b0, s);
      d[i] = s;
    end
    send_bit(~mack, 1'b0, s);
  endtask

  initial begin
    logic       ack;
    logic       s;
    logic [7:0] rd;
    logic [7:0] addr_byte;
    int         stb_snap, drove_snap;

    rst_n  = 1'b0;
    m_scl  = 1'b1;
    m_sda  = 1'b1;
    glitch = 1'b0;
    wclk(5);
    check("rst_scl_tri", 32'(o_scl_tri), 32'd1);
    check("rst_sda_tri", 32'(o_sda_tri), 32'd1);
    check("rst_scl_out", 32'(o_scl_out), 32'd0);
    check("rst_sda_out", 32'(o_sda_out), 32'd0);
    check("rst_wr_stb", 32'(o_wr_stb), 32'd0);
    check("rst_wr_addr", 32'(o_wr_addr), 32'd0);
    check("rst_wr_data", 32'(o_wr_data), 32'd0);
    check("rst_rd_addr", 32'(o_rd_addr), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    rst_n = 1'b1;
    wclk(10);

    // Write 0xA5, 0x5A starting at pointer 0x10
    i2c_start();
    check("wr_busy_start", 32'(o_busy), 32'd1);
    write_byte(8'h84, 8'h00, ack); check("wr_ack_addr", 32'(ack), 32'd1);
    write_byte(8'h10, 8'h00, ack); check("wr_ack_ptr", 32'(ack), 32'd1);
    write_byte(8'hA5, 8'h00, ack); check("wr_ack_d0", 32'(ack), 32'd1);
    write_byte(8'h5A, 8'h00, ack); check("wr_ack_d1", 32'(ack), 32'd1);
    i2c_stop();
    wclk(10);
    check("wr_busy_stop", 32'(o_busy), 32'd0);
    check("wr_stb_count", 32'(stb_n), 32'd2);
    check("wr_stb0_addr", 32'(stb_a[0]), 32'h10);
    check("wr_stb0_data", 32'(stb_d[0]), 32'hA5);
    check("wr_stb1_addr", 32'(stb_a[1]), 32'h11);
    check("wr_stb1_data", 32'(stb_d[1]), 32'h5A);
    check("wr_ptr_after", 32'(o_rd_addr), 32'h12);

    // Combined read: pointer 0x20, repeated start, two bytes
    wclk(20);
    i2c_start();
    write_byte(8'h84, 8'h00, ack); check("rd_ack_waddr", 32'(ack), 32'd1);
    write_byte(8'h20, 8'h00, ack); check("rd_ack_ptr", 32'(ack), 32'd1);
    i2c_start();
    write_byte(8'h85, 8'h00, ack); check("rd_ack_raddr", 32'(ack), 32'd1);
    check("rd_addr0", 32'(o_rd_addr), 32'h20);
    read_byte(1'b1, rd); check("rd_byte0", 32'(rd), 32'h3C);
    check("rd_addr1", 32'(o_rd_addr), 32'h21);
    read_byte(1'b0, rd); check("rd_byte1", 32'(rd), 32'hC3);
    wclk(Q);
    check("rd_sda_released", 32'(o_sda_tri), 32'd1);
    i2c_stop();
    wclk(10);
    check("rd_ptr_after_nack", 32'(o_rd_addr), 32'h21);
    check("rd_busy_stop", 32'(o_busy), 32'd0);

    // Address mismatch: no ACK, no strobe, SDA never driven
    wclk(20);
    stb_snap   = stb_n;
    drove_snap = drove_cnt;
    i2c_start();
    write_byte(8'hA0, 8'h00, ack); check("mm_nack_addr", 32'(ack), 32'd0);
    write_byte(8'h11, 8'h00, ack); check("mm_nack_data", 32'(ack), 32'd0);
    i2c_stop();
    wclk(10);
    check("mm_no_stb", 32'(stb_n - stb_snap), 32'd0);
    check("mm_sda_never_driven", 32'(drove_cnt - drove_snap), 32'd0);

    // Pointer wrap from 0xFF
    wclk(20);
    i2c_start();
    write_byte(8'h84, 8'h00, ack); check("wrap_ack_addr", 32'(ack), 32'd1);
    write_byte(8'hFF, 8'h00, ack); check("wrap_ack_ptr", 32'(ack), 32'd1);
    write_byte(8'h01, 8'h00, ack); check("wrap_ack_d0", 32'(ack), 32'd1);
    write_byte(8'h02, 8'h00, ack); check("wrap_ack_d1", 32'(ack), 32'd1);
    i2c_stop();
    wclk(10);
    check("wrap_stb_count", 32'(stb_n), 32'd4);
    check("wrap_stb0_addr", 32'(stb_a[2]), 32'hFF);
    check("wrap_stb0_data", 32'(stb_d[2]), 32'h01);
    check("wrap_stb1_addr", 32'(stb_a[3]), 32'h00);
    check("wrap_stb1_data", 32'(stb_d[3]), 32'h02);
    check("wrap_ptr_after", 32'(o_rd_addr), 32'h01);

    // Reset while the target drives the address ACK
    wclk(20);
    i2c_start();
    addr_byte = 8'h84;
    for (int i = 7; i >= 0; i--) send_bit(addr_byte[i], 1'b0, s);
    wclk(Q + 5);
    check("rstack_driving", 32'(o_sda_tri), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rstack_sda_released", 32'(o_sda_tri), 32'd1);
    check("rstack_busy", 32'(o_busy), 32'd0);
    wclk(3);
    m_sda = 1'b1;
    m_scl = 1'b1;
    wclk(5);
    rst_n = 1'b1;
    wclk(10);
    check("rstack_ptr_reset", 32'(o_rd_addr), 32'h00);
    i2c_start();
    write_byte(8'h84, 8'h00, ack); check("rstack_ack_addr", 32'(ack), 32'd1);
    write_byte(8'h05, 8'h00, ack); check("rstack_ack_ptr", 32'(ack), 32'd1);
    write_byte(8'h77, 8'h00, ack); check("rstack_ack_data", 32'(ack), 32'd1);
    i2c_stop();
    wclk(10);
    check("rstack_stb_count", 32'(stb_n), 32'd5);
    check("rstack_stb_addr", 32'(stb_a[4]), 32'h05);
    check("rstack_stb_data", 32'(stb_d[4]), 32'h77);

    // One-clk SDA glitches while SCL high must not look like STOP or START
    wclk(20);
    i2c_start();
    write_byte(8'h84, 8'h00, ack); check("gl_ack_addr", 32'(ack), 32'd1);
    write_byte(8'h30, 8'h00, ack); check("gl_ack_ptr", 32'(ack), 32'd1);
    write_byte(8'h7F, 8'hC0, ack); check("gl_ack_data", 32'(ack), 32'd1);
    check("gl_busy", 32'(o_busy), 32'd1);
    i2c_stop();
    wclk(10);
    check("gl_stb_count", 32'(stb_n), 32'd6);
    check("gl_stb_addr", 32'(stb_a[5]), 32'h30);
    check("gl_stb_data", 32'(stb_d[5]), 32'h7F);
    check("gl_busy_stop", 32'(o_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
